// File: rtl/argmax_pkg.sv
// Shared types and defaults for the argmax stream sink.
// Build option: ARGMAX_TIE_LAST_EN (see argmax_8_16.sv).
package argmax_pkg;

    typedef enum logic [0:0] {
        StAccum = 1'b0,
        StHold  = 1'b1
    } state_e;

    localparam int unsigned MDefault = 8;
    localparam int unsigned TDefault = 16;

    // Index width for M elements; never below one bit.
    function automatic int unsigned calc_iw(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Signed T-bit compare deciding whether a new element replaces the running best.
module argmax_cmp #(
    parameter int unsigned T       = 16,
    parameter bit          TieLast = 1'b0
) (
    input  logic [T-1:0] a_i,
    input  logic [T-1:0] b_i,
    output logic         take_o
);

    // TieLast lets an equal value win, so ties resolve to the later index.
    always_comb begin
        if (TieLast) begin
            take_o = $signed(a_i) >= $signed(b_i);
        end else begin
            take_o = $signed(a_i) > $signed(b_i);
        end
    end

endmodule

// File: rtl/argmax_8_16.sv
// Argmax stream sink: accepts M signed T-bit elements per vector over valid/ready and
// emits the 0-based index of the largest one.
// Build option: define ARGMAX_TIE_LAST_EN to resolve ties to the highest index
// (default: lowest index).
module argmax_8_16
    import argmax_pkg::*;
#(
    parameter int unsigned M  = MDefault,
    parameter int unsigned T  = TDefault,
    parameter int unsigned IW = calc_iw(M)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          input_valid,
    output logic          input_ready,
    input  logic [T-1:0]  input_data,
    output logic          output_valid,
    input  logic          output_ready,
    output logic [IW-1:0] output_data
);

`ifdef ARGMAX_TIE_LAST_EN
    localparam bit TieLast = 1'b1;
`else
    localparam bit TieLast = 1'b0;
`endif

    localparam logic [IW-1:0] CntLast = IW'(M - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [T-1:0]  best_q, best_d;
    logic          take;
    logic          in_xfer;

    argmax_cmp #(
        .T       (T),
        .TieLast (TieLast)
    ) u_cmp (
        .a_i    (input_data),
        .b_i    (best_q),
        .take_o (take)
    );

    // Handshake decode from registered state; reset is the only input that gates it.
    always_comb begin
        input_ready  = (state_q == StAccum) && !reset;
        output_valid = (state_q == StHold);
        output_data  = idx_q;
        in_xfer      = input_valid && input_ready;
    end

    // Next-state: track running maximum, switch to HOLD after the M-th element.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        unique case (state_q)
            StAccum: begin
                if (in_xfer) begin
                    // Element 0 seeds the search regardless of the stale best value.
                    if ((cnt_q == '0) || take) begin
                        best_d = input_data;
                        idx_d  = cnt_q;
                    end
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            StHold: begin
                if (output_ready) begin
                    state_d = StAccum;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_argmax_8_16.sv
// Scoreboard bench for argmax_8_16: drivers push expected indices, a monitor pops them
// on each result transfer. Expected tie results follow ARGMAX_TIE_LAST_EN.
module tb_argmax_8_16;

`ifdef ARGMAX_TIE_LAST_EN
    localparam bit TieLast = 1'b1;
`else
    localparam bit TieLast = 1'b0;
`endif

    typedef logic signed [15:0] vec_t [8];

    logic        clk = 1'b0;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [15:0] input_data;
    logic        output_valid;
    logic        output_ready;
    logic [2:0]  output_data;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int cyc = 0;
    bit rdy_rand = 1'b0;
    bit hold_off = 1'b0;
    bit tp_en    = 1'b0;
    bit tp_have  = 1'b0;
    int tp_last  = 0;

    argmax_8_16 dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference argmax for random vectors.
    function automatic int model(input vec_t v);
        logic signed [15:0] b;
        int                 ix;
        b  = v[0];
        ix = 0;
        for (int i = 1; i < 8; i++) begin
            if (TieLast ? (v[i] >= b) : (v[i] > b)) begin
                b  = v[i];
                ix = i;
            end
        end
        return ix;
    endfunction

    // Drive the first n elements of v; entered and left just after a rising edge.
    task automatic send(input vec_t v, input int n, input bit rnd_gap);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc) begin
                input_valid = rnd_gap ? 1'($urandom_range(1, 0)) : 1'b1;
                input_data  = input_valid ? v[i] : 16'hxxxx;
                @(negedge clk);
                acc = input_valid && input_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 500) begin
                    chk("input_accept_timeout", 0, 1);
                    acc = 1'b1;
                end
            end
        end
        input_valid = 1'b0;
        input_data  = 16'hxxxx;
    endtask

    task automatic vec(input vec_t v, input int exp, input bit rnd_gap);
        exp_q.push_back(exp);
        send(v, 8, rnd_gap);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Downstream ready generator.
    initial begin
        output_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            output_ready = hold_off ? 1'b0 : (rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1);
        end
    end

    // Monitor: result transfers against the scoreboard, stall stability, throughput.
    initial begin
        bit         stall;
        logic [2:0] sd;
        int         e;
        stall = 1'b0;
        sd    = '0;
        forever begin
            @(negedge clk);
            if (stall) begin
                chk("stall_valid_held", int'(output_valid), 1);
                chk("stall_data_stable", int'(output_data), int'(sd));
            end
            if (output_valid) chk("no_accept_in_hold", int'(input_ready), 0);
            stall = output_valid && !output_ready && !reset;
            sd    = output_data;
            if (output_valid && output_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_index", int'(output_data), e);
                end
                if (tp_en) begin
                    if (tp_have) chk("cycles_per_vector", cyc - tp_last, 9);
                    tp_have = 1'b1;
                    tp_last = cyc;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset       = 1'b1;
        input_valid = 1'b0;
        input_data  = 16'hxxxx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_input_ready", int'(input_ready), 0);
        chk("reset_output_valid", int'(output_valid), 0);
        chk("reset_output_data", int'(output_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(input_ready), 1);
        @(posedge clk);
        #1;

        // Basic vector and latency.
        v = '{16'sd1, 16'sd5, 16'sd3, -16'sd2, 16'sd7, 16'sd0, 16'sd4, 16'sd6};
        vec(v, 4, 1'b0);
        chk("latency_valid", int'(output_valid), 1);
        drain();

        v = '{-16'sd8, -16'sd3, -16'sd100, 16'sh8000, -16'sd3, -16'sd50, -16'sd9, -16'sd4};
        vec(v, TieLast ? 4 : 1, 1'b0);
        v = '{default: 16'sh7FFF};
        vec(v, TieLast ? 7 : 0, 1'b0);
        // Only a signed compare picks 0x7FFF over 0x8000 and 0xFFFF.
        v = '{16'sh8000, -16'sd1, 16'sh8000, 16'sh7FFF, 16'sh7FFE, 16'sd0, 16'sd0, 16'sd0};
        vec(v, 3, 1'b0);
        v = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd7};
        vec(v, 7, 1'b0);
        drain();

        // Back-to-back throughput: max placed at k%8.
        tp_have = 1'b0;
        tp_en   = 1'b1;
        for (int k = 0; k < 100; k++) begin
            for (int i = 0; i < 8; i++) v[i] = (i == k % 8) ? 16'sd1000 : 16'(i - k);
            vec(v, k % 8, 1'b0);
        end
        drain();
        tp_en = 1'b0;

        // Random gaps on both sides against the reference model.
        rdy_rand = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < 8; i++) begin
                v[i] = (k % 2 == 0) ? 16'($urandom_range(65535, 0))
                                    : 16'($signed($urandom_range(7, 0)) - 4);
            end
            vec(v, model(v), 1'b1);
        end
        drain();
        rdy_rand = 1'b0;

        // Reset mid-vector: the partial elements must vanish.
        v = '{default: 16'sd100};
        send(v, 5, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        v = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd9};
        vec(v, 7, 1'b0);
        drain();

        // Reset during HOLD: the pending index is dropped.
        hold_off = 1'b1;
        @(posedge clk);
        #1;
        v = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd50, 16'sd6, 16'sd7, 16'sd8};
        send(v, 8, 1'b0);
        chk("hold_valid", int'(output_valid), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("hold_reset_valid", int'(output_valid), 0);
        chk("hold_reset_ready", int'(input_ready), 1);
        @(posedge clk);
        #1;
        hold_off = 1'b0;
        v = '{16'sd3, 16'sd1, 16'sd2, 16'sd9, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        vec(v, 3, 1'b0);
        drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
